// File: rtl/pll_ce_nco_if.sv
// Configuration bus for pll_ce_nco: shadow-register writes and the global apply strobe.
// The master drives requests; the slave (the NCO block) returns cfg_ready.
interface pll_ce_nco_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ACC_W    = 32
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_chan;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;
  logic             cfg_apply;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_inc,
    output cfg_phase,
    output cfg_apply,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_inc,
    input  cfg_phase,
    input  cfg_apply,
    output cfg_ready
  );
endinterface

// File: rtl/pll_ce_nco.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators whose
// carries become one-cycle enables, gated by a debounced, synchronised PLL lock.
module pll_ce_nco #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned SETTLE   = 1024
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  pll_ce_nco_if.slave         cfg,
  output logic [CHANNELS-1:0] ce,
  output logic                locked
);

  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    StWait,
    StSettle,
    StRun
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lk_meta_q, lk_s_q;
  logic             ready_q, ready_d;

  logic [ACC_W-1:0] shadow_inc_q   [CHANNELS];
  logic [ACC_W-1:0] shadow_inc_d   [CHANNELS];
  logic [ACC_W-1:0] shadow_phase_q [CHANNELS];
  logic [ACC_W-1:0] shadow_phase_d [CHANNELS];
  logic [ACC_W-1:0] act_inc_q      [CHANNELS];
  logic [ACC_W-1:0] act_inc_d      [CHANNELS];
  logic [ACC_W-1:0] act_phase_q    [CHANNELS];
  logic [ACC_W-1:0] act_phase_d    [CHANNELS];
  logic [ACC_W-1:0] acc_q          [CHANNELS];
  logic [ACC_W-1:0] acc_d          [CHANNELS];
  logic [ACC_W:0]   sum            [CHANNELS];
  logic [CHANNELS-1:0] ce_q, ce_d;

  logic wr_fire, ap_fire, count_en;

  assign wr_fire  = cfg.cfg_valid & ready_q;
  assign ap_fire  = cfg.cfg_apply & ready_q;
  // Counting stops in the same cycle the synchronised lock drops, so ce never
  // outlives RUN by a cycle.
  assign count_en = (state_q == StRun) && lk_s_q;

  assign cfg.cfg_ready = ready_q;
  assign ce            = ce_q;
  assign locked        = (state_q == StRun);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        if (lk_s_q) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (!lk_s_q) begin
          state_d = StWait;
        end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        if (!lk_s_q) begin
          state_d = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // An accepted apply takes one cycle of back-pressure so the reload settles.
  assign ready_d = ~ap_fire;

  always_comb begin
    ce_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      shadow_inc_d[i]   = shadow_inc_q[i];
      shadow_phase_d[i] = shadow_phase_q[i];
      if (wr_fire && (cfg.cfg_chan == CH_W'(i))) begin
        shadow_inc_d[i]   = cfg.cfg_inc;
        shadow_phase_d[i] = cfg.cfg_phase;
      end

      act_inc_d[i]   = ap_fire ? shadow_inc_d[i]   : act_inc_q[i];
      act_phase_d[i] = ap_fire ? shadow_phase_d[i] : act_phase_q[i];

      sum[i] = {1'b0, acc_q[i]} + {1'b0, act_inc_q[i]};
      if (ap_fire) begin
        acc_d[i] = shadow_phase_d[i];
      end else if (count_en) begin
        acc_d[i] = sum[i][ACC_W-1:0];
        ce_d[i]  = sum[i][ACC_W];
      end else begin
        acc_d[i] = act_phase_q[i];
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= StWait;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ce_q    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_inc_q[i]   <= '0;
        shadow_phase_q[i] <= '0;
        act_inc_q[i]      <= '0;
        act_phase_q[i]    <= '0;
        acc_q[i]          <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ce_q    <= ce_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_inc_q[i]   <= shadow_inc_d[i];
        shadow_phase_q[i] <= shadow_phase_d[i];
        act_inc_q[i]      <= act_inc_d[i];
        act_phase_q[i]    <= act_phase_d[i];
        acc_q[i]          <= acc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pll_ce_nco.sv
// Scoreboard bench for pll_ce_nco: stimulus queues hand-computed expectations tagged with
// a cycle number; a negedge monitor pops and compares them and counts ce pulses.
module tb_pll_ce_nco;

  localparam int unsigned CHANNELS = 5;
  localparam int unsigned ACC_W    = 32;
  localparam int unsigned SETTLE   = 16;

  localparam int KLocked = 0;
  localparam int KReady  = 1;
  localparam int KCe     = 2;
  localparam int KCount  = 3;
  localparam int KClear  = 4;

  typedef struct {
    int unsigned cyc;
    int          kind;
    int          ch;
    int unsigned val;
    int unsigned tol;
    string       name;
  } exp_t;

  logic                refclk = 1'b0;
  logic                rst;
  logic                pll_locked;
  logic [CHANNELS-1:0] ce;
  logic                locked;

  pll_ce_nco_if #(.CHANNELS(CHANNELS), .ACC_W(ACC_W)) bus ();

  pll_ce_nco #(
    .CHANNELS(CHANNELS),
    .ACC_W   (ACC_W),
    .SETTLE  (SETTLE)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .cfg       (bus),
    .ce        (ce),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int unsigned cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   pcnt [CHANNELS];
  exp_t e;
  int unsigned got;
  int          diff;

  always @(negedge refclk) begin
    for (int c = 0; c < int'(CHANNELS); c++) if (ce[c]) pcnt[c]++;
    for (int k = int'(sb.size()) - 1; k >= 0; k--) begin
      if (sb[k].cyc <= cyc) begin
        e = sb[k];
        sb.delete(k);
        if (e.kind == KClear) begin
          for (int c = 0; c < int'(CHANNELS); c++) pcnt[c] = 0;
        end else if (e.cyc < cyc) begin
          tests++;
          failed++;
          $display("FAIL %s: check for cycle %0d was not reached (now %0d)", e.name, e.cyc, cyc);
        end else begin
          case (e.kind)
            KLocked: got = {31'b0, locked};
            KReady:  got = {31'b0, bus.cfg_ready};
            KCe:     got = {27'b0, ce};
            default: got = pcnt[e.ch];
          endcase
          diff = int'(got) - int'(e.val);
          if (diff < 0) diff = -diff;
          tests++;
          if (diff > int'(e.tol)) begin
            failed++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h (tol %0d)",
                     e.name, cyc, got, e.val, e.tol);
          end
        end
      end
    end
  end

  task automatic expect_at(input int kind, input int unsigned off, input int ch,
                           input int unsigned val, input int unsigned tol, input string name);
    exp_t x;
    x.cyc  = cyc + off;
    x.kind = kind;
    x.ch   = ch;
    x.val  = val;
    x.tol  = tol;
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic exp_ce(input int unsigned off, input int unsigned val, input string name);
    expect_at(KCe, off, 0, val, 0, name);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic write(input int unsigned ch, input logic [31:0] inc, input logic [31:0] ph);
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = ch[2:0];
    bus.cfg_inc   = inc;
    bus.cfg_phase = ph;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // Ch0 at inc 0xC000_0000, ch1 0x4000_0000, ch2 0x5555_5555, all phase 0, apply at 'now'.
  task automatic expect_after_apply(input string tag);
    expect_at(KReady, 0, 0, 1, 0, {tag, "_ready_at_apply"});
    expect_at(KReady, 1, 0, 0, 0, {tag, "_ready_low"});
    expect_at(KReady, 2, 0, 1, 0, {tag, "_ready_back"});
    exp_ce(1, 5'b00000, {tag, "_ce_quiet1"});
    exp_ce(2, 5'b00000, {tag, "_ce_quiet2"});
    exp_ce(3, 5'b00001, {tag, "_ce3"});
    exp_ce(4, 5'b00001, {tag, "_ce4"});
    exp_ce(5, 5'b00111, {tag, "_ce5"});
    exp_ce(6, 5'b00000, {tag, "_ce6"});
    exp_ce(7, 5'b00001, {tag, "_ce7"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests + 1, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < int'(CHANNELS); c++) pcnt[c] = 0;
    rst           = 1'b1;
    pll_locked    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_chan  = '0;
    bus.cfg_inc   = '0;
    bus.cfg_phase = '0;
    bus.cfg_apply = 1'b0;

    repeat (3) tick();
    expect_at(KReady, 0, 0, 0, 0, "reset_ready");
    expect_at(KLocked, 0, 0, 0, 0, "reset_locked");
    exp_ce(0, 5'b00000, "reset_ce");
    rst = 1'b0;
    expect_at(KReady, 1, 0, 1, 0, "ready_after_reset");
    tick();

    write(0, 32'h8000_0000, 32'h0);
    write(1, 32'h4000_0000, 32'h0);
    write(2, 32'h5555_5555, 32'h0);
    write(3, 32'h0, 32'h0);
    bus.cfg_apply = 1'b1;
    tick();
    bus.cfg_apply = 1'b0;
    tick();

    // Lock acquisition: RUN begins 19 cycles after the pll_locked edge.
    pll_locked = 1'b1;
    expect_at(KReady, 0, 0, 1, 0, "ready_before_lock");
    exp_ce(5, 5'b00000, "ce_in_settle");
    exp_ce(18, 5'b00000, "ce_before_run");
    expect_at(KLocked, 18, 0, 0, 0, "locked_early");
    expect_at(KLocked, 19, 0, 1, 0, "locked_rise");
    exp_ce(19, 5'b00000, "run1");
    exp_ce(20, 5'b00000, "run2");
    exp_ce(21, 5'b00001, "run3");
    exp_ce(22, 5'b00000, "run4");
    exp_ce(23, 5'b00111, "run5");
    exp_ce(24, 5'b00000, "run6");
    exp_ce(25, 5'b00001, "run7");
    exp_ce(26, 5'b00100, "run8");
    exp_ce(27, 5'b00011, "run9");
    repeat (30) tick();

    expect_at(KClear, 1, 0, 0, 0, "clear");
    expect_at(KCount, 1001, 0, 500, 1, "rate_ch0");
    expect_at(KCount, 1001, 1, 250, 1, "rate_ch1");
    expect_at(KCount, 3001, 2, 1000, 1, "rate_ch2");
    expect_at(KCount, 3001, 3, 0, 0, "rate_ch3_zero");
    expect_at(KCount, 3001, 4, 0, 0, "rate_ch4_zero");
    repeat (3005) tick();

    // Write and apply in the same cycle during RUN.
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = 3'd0;
    bus.cfg_inc   = 32'hC000_0000;
    bus.cfg_phase = 32'h0;
    bus.cfg_apply = 1'b1;
    expect_after_apply("wr_apply");
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_apply = 1'b0;
    repeat (10) tick();

    // Out-of-range channel must leave every channel untouched.
    write(7, 32'hFFFF_FFFF, 32'h1234_5678);
    bus.cfg_apply = 1'b1;
    expect_after_apply("chan7");
    tick();
    bus.cfg_apply = 1'b0;
    repeat (10) tick();

    // Lock loss for 5 cycles, then re-acquire.
    pll_locked = 1'b0;
    expect_at(KLocked, 2, 0, 1, 0, "drop_locked_still");
    expect_at(KLocked, 3, 0, 0, 0, "drop_locked_low");
    exp_ce(3, 5'b00000, "drop_ce_low");
    exp_ce(10, 5'b00000, "drop_ce_idle");
    expect_at(KLocked, 23, 0, 0, 0, "relock_early");
    expect_at(KLocked, 24, 0, 1, 0, "relock_rise");
    exp_ce(24, 5'b00000, "relock1");
    exp_ce(25, 5'b00000, "relock2");
    exp_ce(26, 5'b00001, "relock3");
    exp_ce(27, 5'b00001, "relock4");
    exp_ce(28, 5'b00111, "relock5");
    exp_ce(29, 5'b00000, "relock6");
    repeat (5) tick();
    pll_locked = 1'b1;
    repeat (30) tick();

    // Asynchronous reset mid-RUN; afterwards everything is back to zero rates.
    rst = 1'b1;
    expect_at(KLocked, 0, 0, 0, 0, "arst_locked");
    expect_at(KReady, 0, 0, 0, 0, "arst_ready");
    exp_ce(0, 5'b00000, "arst_ce");
    repeat (2) tick();
    rst = 1'b0;
    expect_at(KReady, 1, 0, 1, 0, "arst_ready_back");
    expect_at(KLocked, 18, 0, 0, 0, "arst_relock_early");
    expect_at(KLocked, 19, 0, 1, 0, "arst_relock");
    exp_ce(22, 5'b00000, "arst_inc_cleared_a");
    exp_ce(23, 5'b00000, "arst_inc_cleared_b");
    exp_ce(25, 5'b00000, "arst_inc_cleared_c");
    repeat (30) tick();

    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
